// File: rtl/ring_dec_if.sv
// Bus bundle for ring_dec: sampled ring vector in, decoded index and status out.
interface ring_dec_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]     ring_in;
  logic                 in_valid;
  logic                 clr_err;
  logic [IdxW-1:0]      idx;
  logic                 idx_valid;
  logic                 locked;
  logic                 err;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Producer of samples / consumer of status.
  modport master (
    output ring_in, in_valid, clr_err,
    input  idx, idx_valid, locked, err, err_sticky, err_cnt
  );

  // The decoder itself.
  modport slave (
    input  ring_in, in_valid, clr_err,
    output idx, idx_valid, locked, err, err_sticky, err_cnt
  );
endinterface

// File: rtl/ring_dec.sv
// One-hot ring-counter decoder and rotation-sequence checker.
// Optional feature: define RING_DEC_ERRCNT_EN for a live saturating err_cnt;
// otherwise err_cnt is tied to zero.
module ring_dec #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic       clk,
  input logic       rst,
  ring_dec_if.slave bus
);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CntW-1:0]  match_cnt_q, match_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;

  logic             legal;
  logic             match;
  logic [IdxW-1:0]  hot_idx;
  logic [WIDTH-1:0] expected;
  logic [CntW-1:0]  cnt_inc;

  // Classify the incoming sample and encode its hot position.
  always_comb begin
    legal    = (bus.ring_in != '0) && ((bus.ring_in & (bus.ring_in - WIDTH'(1))) == '0);
    expected = {prev_q[0], prev_q[WIDTH-1:1]};
    match    = (bus.ring_in == expected);
    cnt_inc  = match_cnt_q + CntW'(1);
    hot_idx  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.ring_in[i]) hot_idx = IdxW'(i);
    end
  end

  // Lock FSM next-state, stored sample, index and error pulse.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    err_d       = 1'b0;
    if (bus.in_valid) begin
      if (legal) begin
        idx_d       = hot_idx;
        idx_valid_d = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (legal) begin
            prev_d      = bus.ring_in;
            match_cnt_d = '0;
            state_d     = StAcquire;
          end else begin
            err_d = 1'b1;
          end
        end
        StAcquire: begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (match) begin
            prev_d      = bus.ring_in;
            match_cnt_d = cnt_inc;
            if (cnt_inc == CntW'(LOCK_CNT)) state_d = StLocked;
          end else begin
            // A mismatch while still acquiring just restarts from this sample.
            prev_d      = bus.ring_in;
            match_cnt_d = '0;
          end
        end
        StLocked: begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (match) begin
            prev_d = bus.ring_in;
          end else begin
            err_d       = 1'b1;
            prev_d      = bus.ring_in;
            match_cnt_d = '0;
            state_d     = StAcquire;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sticky flag: clear takes effect before a coincident error.
  always_comb begin
    err_sticky_d = bus.clr_err ? 1'b0 : err_sticky_q;
    if (err_d) err_sticky_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_cnt_q  <= match_cnt_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef RING_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] cnt_base;

  // Saturating error counter; clear applies before a coincident error.
  always_comb begin
    cnt_base  = bus.clr_err ? '0 : err_cnt_q;
    err_cnt_d = cnt_base;
    if (err_d && (cnt_base != '1)) err_cnt_d = cnt_base + ERR_CNT_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.idx        = idx_q;
  assign bus.idx_valid  = idx_valid_q;
  assign bus.locked     = (state_q == StLocked);
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: doc/ring_dec.md
# ring_dec

One-hot ring-counter decoder and sequence checker: the receiving end of a 4-bit rotating ring counter.
- Samples the ring's one-hot vector and converts the hot position to a binary index.
- Verifies that each new sample is the correct right-rotation of the previous one.
- Reports lock, illegal-pattern and sequence errors to the control/status logic that consumes ring-counter phases.

## Interface
Parameters:
- WIDTH, 4, ring width in bits (≥2).
- LOCK_CNT, 2, consecutive correct rotations required to declare lock (≥1).
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- ring_in  input  WIDTH  ring counter vector to check.
- in_valid  input  1  ring_in is a new sample this cycle.
- clr_err  input  1  clears err_sticky and err_cnt.
- idx  output  $clog2(WIDTH)  binary position of the hot bit of the last valid one-hot sample.
- idx_valid  output  1  idx holds a decoded value.
- locked  output  1  sequence locked.
- err  output  1  one-cycle error pulse.
- err_sticky  output  1  error seen since reset or the last clr_err.
- err_cnt  output  ERR_CNT_W  saturating error count.

## Operation
- Legal sample: exactly one bit of ring_in set. Zero bits or more than one bit set is illegal.
- Expected next sample = {prev[0], prev[WIDTH-1:1]}, where prev is the last stored sample.
  - Example: 1000 → 0100 → 0010 → 0001 → 1000.
- Stored sample (prev) and match_cnt are internal registers.
- When in_valid=0:
  - No state changes.
  - err=0.
  - All other outputs hold.
- On every legal valid sample:
  - idx is loaded with the hot-bit position (bit i → i).
  - idx_valid is set to 1.
- An illegal sample does not update idx or prev.

State machine (state register resets to IDLE):
- IDLE
  - Legal sample → store it, match_cnt=0, go to ACQUIRE.
  - Illegal sample → err, stay in IDLE.
- ACQUIRE
  - Legal sample equal to expected → match_cnt+1. Go to LOCKED when match_cnt+1 == LOCK_CNT.
  - Legal sample not equal to expected → store it, match_cnt=0, stay in ACQUIRE, no err.
  - Illegal sample → err, go to IDLE.
- LOCKED
  - Legal sample equal to expected → store it, stay in LOCKED.
  - Legal mismatch → err, store it, match_cnt=0, go to ACQUIRE.
  - Illegal sample → err, go to IDLE.
- locked = (state == LOCKED).

Error status:
- Every err pulse sets err_sticky and increments err_cnt.
- err_cnt saturates at all-ones; no wrap.
- clr_err clears err_sticky and err_cnt.
- clr_err coincident with a new error: the clear applies first, then the error. Result: err_sticky=1, err_cnt=1.

## Timing
- All outputs are registered. The response appears the cycle after the sampling edge, i.e. 1-cycle latency from in_valid.
- err is high for exactly one cycle per errored sample.
- Back-to-back samples are supported every cycle.
- Lock timing: locked rises on the edge that registers the LOCK_CNT-th consecutive match. Minimum is LOCK_CNT+1 valid samples after IDLE.
- locked falls on the same edge that raises err.
- Reset values:
  - idx=0, idx_valid=0
  - locked=0
  - err=0, err_sticky=0, err_cnt=0
  - state=IDLE, prev=0, match_cnt=0
- Reset asserted mid-sequence: outputs clear asynchronously. The sequence must be re-acquired after reset deasserts.
- Wrap-around (0001 → 1000) is a normal match.

## Configuration
- RING_DEC_ERRCNT_EN defined:
  - err_cnt is a live saturating counter as above.
- RING_DEC_ERRCNT_EN undefined:
  - The counter logic is removed and err_cnt is tied to 0.
  - err and err_sticky behave identically in both configurations.

## Test plan
All scenarios use WIDTH=4, LOCK_CNT=2.
- Reset check: hold rst=1 → idx=0, idx_valid=0, locked=0, err=0, err_sticky=0, err_cnt=0.
- Acquisition and wrap: valid samples 1000, 0100, 0010 → idx=3, 2, 1 and locked=1 after the third sample. Continue with 0001, 1000 → locked stays 1, idx=0 then 3, err never asserted.
- Sequence break: lock as above, then feed 1000 where 0001 is expected → err pulse 1 cycle, locked=0, err_cnt=1, idx=3. Then 0100, 0010 → locked=1 again.
- Illegal patterns: feed 0000, then 1100 while locked → two err pulses, state IDLE, err_cnt=2, idx unchanged.
- Error clear and saturation, with ERR_CNT_W=2:
  - Feed 5 illegal samples → err_cnt=3.
  - Assert clr_err together with a 6th illegal sample → err_cnt=1, err_sticky=1.
  - Assert clr_err alone → err_cnt=0, err_sticky=0.
- Gating and async reset: hold in_valid=0 with garbage on ring_in → no output change. Assert rst mid-lock between clock edges → locked=0 immediately.
